logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the basic two-input gate block.
- Applies one of eight bitwise operations to W-bit operands and registers the result.
- Adds result flags and a saturating completed-operation counter.
- Sits between a valid/ready producer and consumer on the datapath. It gives full throughput and propagates backpressure.

---
 rtl/logic_unit_pipe_if.sv | 30 +++
 rtl/logic_unit_pipe.sv | 112 +++++++++++
 tb/tb_logic_unit_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Valid/ready bundle for logic_unit_pipe: producer side, consumer side and counter control.
// The master drives requests and out_ready; the slave (the pipe) drives results.
interface logic_unit_pipe_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     y;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [CNT_W-1:0] op_count;
    logic             clr_count;

    modport master (
        output in_valid, a, b, op, out_ready, clr_count,
        input  in_ready, out_valid, y, zero, ones, parity, op_count
    );

    modport slave (
        input  in_valid, a, b, op, out_ready, clr_count,
        output in_ready, out_valid, y, zero, ones, parity, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with result flags and a saturating handshake counter.
// S1 captures operands, S2 computes and registers the result; full throughput with backpressure.
module logic_unit_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    logic_unit_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_a_d;
    logic [W-1:0]     s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load, s1_load, in_hs, out_hs;
    logic [W-1:0]     res;

    always_comb begin
        // in_ready depends on out_ready only, never on in_valid
        s2_load = bus.out_ready | ~out_valid_q;
        s1_load = ~s1_valid_q | s2_load;
        in_hs   = bus.in_valid & s1_load;
        out_hs  = out_valid_q & bus.out_ready;

        res = s1_a_q;
        case (s1_op_q)
            3'd0: res = s1_a_q | s1_b_q;
            3'd1: res = s1_a_q & s1_b_q;
            3'd2: res = ~(s1_a_q | s1_b_q);
            3'd3: res = ~(s1_a_q & s1_b_q);
            3'd4: res = ~s1_a_q;
            3'd5: res = s1_a_q ^ s1_b_q;
            3'd6: res = ~(s1_a_q ^ s1_b_q);
            default: res = s1_a_q;
        endcase

        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;

        if (s1_load) s1_valid_d = bus.in_valid;
        if (in_hs) begin
            s1_a_d  = bus.a;
            s1_b_d  = bus.b;
            s1_op_d = bus.op;
        end

        // On a bubble y/flags keep their last value; only out_valid drops
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d      = res;
                zero_d   = ~|res;
                ones_d   = &res;
                parity_d = ^res;
            end
        end

        if (bus.clr_count)                 cnt_d = '0;
        else if (out_hs && cnt_q != CNT_MAX) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.parity    = parity_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed + random bench for logic_unit_pipe with a queue-based reference model.
// A second instance with a 3-bit counter exercises saturation and clear priority.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.W(8), .CNT_W(16)) bus1 ();
    logic_unit_pipe_if #(.W(8), .CNT_W(3))  bus2 ();

    logic_unit_pipe #(.W(8), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    logic_unit_pipe #(.W(8), .CNT_W(3))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_in = 0, n_out = 0, n_out2 = 0;
    int model_cnt = 0, model_cnt2 = 0;
    bit chk_lat = 0;
    logic last_ih;
    logic [7:0] last_y;
    logic last_zero, last_ones, last_parity;
    logic [7:0] exp_q[$];
    int         lat_q[$];
    logic [7:0] log_q[$];

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a | b;
            3'd1: return a & b;
            3'd2: return ~(a | b);
            3'd3: return ~(a & b);
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check counters, score handshakes at negedge, then advance to just after posedge
    task automatic cycle();
        logic ih, oh, oh2;
        logic [7:0] e;
        int l;
        @(negedge clk);
        chk("op_count", bus1.op_count, model_cnt);
        chk("op_count_w3", bus2.op_count, model_cnt2);
        ih  = bus1.in_valid & bus1.in_ready;
        oh  = bus1.out_valid & bus1.out_ready;
        oh2 = bus2.out_valid & bus2.out_ready;
        if (oh) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL spurious_out observed=%0h expected=none", bus1.y);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                chk("y", bus1.y, e);
                chk("zero", bus1.zero, (e == 8'h00));
                chk("ones", bus1.ones, (e == 8'hFF));
                chk("parity", bus1.parity, $countones(e) % 2);
                if (chk_lat) chk("latency", cyc - l, 2);
            end
            log_q.push_back(bus1.y);
            last_y = bus1.y; last_zero = bus1.zero; last_ones = bus1.ones; last_parity = bus1.parity;
            n_out++;
        end
        if (ih) begin
            exp_q.push_back(ref_op(bus1.op, bus1.a, bus1.b));
            lat_q.push_back(cyc);
            n_in++;
        end
        if (bus1.clr_count) model_cnt = 0;
        else if (oh && model_cnt < 65535) model_cnt++;
        if (bus2.clr_count) model_cnt2 = 0;
        else if (oh2 && model_cnt2 < 7) model_cnt2++;
        if (oh2) n_out2++;
        last_ih = ih;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_exp [8];
        logic [7:0] t3_a [4];
        int acc, guard, base;
        t1_exp = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hC5};
        t3_a   = '{8'h11, 8'h22, 8'h33, 8'h44};

        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.op = 0; bus1.out_ready = 0; bus1.clr_count = 0;
        bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.op = 0; bus2.out_ready = 0; bus2.clr_count = 0;

        // Reset state
        #12;
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_y", bus1.y, 0);
        chk("rst_zero", bus1.zero, 1);
        chk("rst_ones", bus1.ones, 0);
        chk("rst_parity", bus1.parity, 0);
        chk("rst_op_count", bus1.op_count, 0);
        chk("rst_out_valid_w3", bus2.out_valid, 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        chk("rst_in_ready", bus1.in_ready, 1);

        // 1: opcode sweep back-to-back
        chk_lat = 1; log_q.delete();
        bus1.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            bus1.in_valid = 1; bus1.a = 8'hC5; bus1.b = 8'h3A; bus1.op = 3'(i);
            cycle();
        end
        bus1.in_valid = 0;
        repeat (4) cycle();
        chk("t1_nout", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) chk("t1_y", log_q[i], t1_exp[i]);
        chk("t1_count", bus1.op_count, 8);

        // 2: flags
        bus1.in_valid = 1; bus1.op = 5; bus1.a = 8'h5A; bus1.b = 8'h5A; cycle();
        bus1.in_valid = 0; repeat (3) cycle();
        chk("t2a_y", last_y, 8'h00); chk("t2a_zero", last_zero, 1);
        chk("t2a_ones", last_ones, 0); chk("t2a_parity", last_parity, 0);
        bus1.in_valid = 1; bus1.op = 7; bus1.a = 8'hFF; bus1.b = 8'h00; cycle();
        bus1.in_valid = 0; repeat (3) cycle();
        chk("t2b_y", last_y, 8'hFF); chk("t2b_zero", last_zero, 0);
        chk("t2b_ones", last_ones, 1); chk("t2b_parity", last_parity, 0);
        bus1.in_valid = 1; bus1.op = 7; bus1.a = 8'h01; cycle();
        bus1.in_valid = 0; repeat (3) cycle();
        chk("t2c_y", last_y, 8'h01); chk("t2c_parity", last_parity, 1);

        // 3: backpressure
        chk_lat = 0; log_q.delete(); acc = 0; base = n_out;
        bus1.out_ready = 0;
        for (int k = 0; k < 6; k++) begin
            bus1.in_valid = 1; bus1.op = 7; bus1.a = t3_a[acc]; bus1.b = 8'h00;
            cycle();
            if (last_ih) acc++;
        end
        chk("t3_accepted", acc, 2);
        chk("t3_in_ready", bus1.in_ready, 0);
        chk("t3_out_valid", bus1.out_valid, 1);
        chk("t3_y_held", bus1.y, 8'h11);
        chk("t3_no_out", n_out - base, 0);
        bus1.out_ready = 1; guard = 0;
        while (acc < 4 && guard < 20) begin
            bus1.in_valid = 1; bus1.a = t3_a[acc];
            cycle();
            if (last_ih) acc++;
            guard++;
        end
        chk("t3_all_in", acc, 4);
        bus1.in_valid = 0;
        repeat (4) cycle();
        chk("t3_nout", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("t3_order", log_q[i], t3_a[i]);

        // 4: random traffic
        for (int k = 0; k < 1000; k++) begin
            bus1.in_valid  = 1'($urandom_range(0, 1));
            bus1.out_ready = 1'($urandom_range(0, 1));
            bus1.a  = 8'($urandom);
            bus1.b  = 8'($urandom);
            bus1.op = 3'($urandom);
            cycle();
        end
        bus1.in_valid = 0; bus1.out_ready = 1;
        repeat (4) cycle();
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_in_eq_out", n_in, n_out);
        chk("t4_count", bus1.op_count, n_out);

        // 5: saturation and clear priority on the 3-bit counter
        bus2.in_valid = 1; bus2.out_ready = 1; bus2.op = 0; guard = 0;
        while (n_out2 < 9 && guard < 40) begin
            bus2.a = 8'($urandom); bus2.b = 8'($urandom);
            cycle();
            guard++;
        end
        bus2.in_valid = 0; bus2.out_ready = 0;
        chk("t5_hs9", n_out2, 9);
        cycle();
        chk("t5_saturated", bus2.op_count, 7);
        chk("t5_out_valid", bus2.out_valid, 1);
        bus2.clr_count = 1; bus2.out_ready = 1;
        cycle();
        bus2.clr_count = 0; bus2.out_ready = 0;
        chk("t5_clr_wins", bus2.op_count, 0);
        bus2.out_ready = 1;
        cycle();
        bus2.out_ready = 0;
        chk("t5_after_clr", bus2.op_count, 1);

        // 6: async reset with two transactions in flight
        bus1.out_ready = 0;
        bus1.in_valid = 1; bus1.op = 7; bus1.a = 8'hA5; cycle();
        bus1.a = 8'h5A; cycle();
        bus1.in_valid = 0;
        chk("t6_pre_valid", bus1.out_valid, 1);
        #2 rst = 1;
        #1;
        chk("t6_async_out_valid", bus1.out_valid, 0);
        chk("t6_async_count", bus1.op_count, 0);
        exp_q.delete(); lat_q.delete();
        model_cnt = 0; model_cnt2 = 0;
        base = n_out;
        #1 rst = 0;
        bus1.out_ready = 1;
        cycle();
        chk("t6_in_ready", bus1.in_ready, 1);
        repeat (5) cycle();
        chk("t6_no_stale", n_out - base, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
